diff_stream_decoder: RTL and testbench
======================================

Name: diff_stream_decoder

Overview:
- Receive-side counterpart of the team's 2-state Mealy differential line encoder.
- Encoder rule, with line state reset to 0: line(t) = data(t) XOR line(t-1).
- This block recovers data(t) = line(t) XOR line(t-1), hunts for a sync word in the decoded stream, then deserializes a fixed number of WIDTH-bit words per frame.
- Sits between the serial line sampler and the word-level consumer.

Parameters:
- WIDTH, 8, bits per word and sync-word length.
- SYNC, 8'hA5, sync pattern compared MSB-first against the last WIDTH decoded bits.
- FRAME_WORDS, 4, data words captured after each sync before returning to hunt (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- in_valid  input  1  qualifies in_bit; the block advances only on cycles with in_valid=1.
- in_bit  input  1  encoded line bit.
- dec_valid  output  1  registered copy of in_valid.
- dec_bit  output  1  registered decoded bit.
- sync_found  output  1  one-cycle pulse when SYNC is matched.
- locked  output  1  high while in DATA state.
- word_out  output  WIDTH  last completed word, MSB = first received bit.
- word_valid  output  1  one-cycle pulse when word_out updates.
- frame_done  output  1  one-cycle pulse when the last word of a frame completes.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears:
  - prev (last line bit) to 0;
  - all outputs to 0;
  - shift register, fill count, bit count and word count to 0;
  - state to HUNT.
- Decode:
  - d = in_bit XOR prev.
  - On an in_valid cycle: prev <= in_bit, dec_bit <= d, dec_valid <= 1.
  - On an in_valid=0 cycle: prev, shift, counters, state and word_out hold; dec_valid, sync_found, word_valid and frame_done are 0.
- Latency: every output responds 1 clk after the qualifying in_valid edge.
- Shift register: sh <= {sh[WIDTH-2:0], d} on each valid bit, in both states.
- HUNT:
  - fill counts valid bits up to a saturation value of WIDTH.
  - Match condition: {sh[WIDTH-2:0], d} == SYNC, and fill >= WIDTH-1 (i.e. the current bit is at least the WIDTH-th since entering HUNT).
  - On match: sync_found=1, locked=1, state DATA, bit count=0, word count=0.
- DATA:
  - Each valid bit increments bit count.
  - On the WIDTH-th bit: word_out <= {sh[WIDTH-2:0], d}, word_valid=1, bit count=0, word count+1.
  - If that word is number FRAME_WORDS, also: frame_done=1, state HUNT, locked=0, fill=0.
  - No sync comparison is made in DATA; a SYNC pattern inside the payload is data.
- Re-sync:
  - After frame_done, fill restarts at 0, so the next sync needs WIDTH fresh bits.
  - Sync words may not overlap the previous frame.
- Gaps: in_valid gaps of any length mid-word or mid-sync are transparent; the result is identical to a gapless stream.
- Simultaneous events: the last-word pulse asserts word_valid and frame_done in the same cycle, with locked falling in that cycle.
- Reset mid-frame: a partial word is discarded, no pulses are issued, and prev returns to 0. The encoder must also be reset to keep line-state agreement.
- Counters: bit count needs $clog2(WIDTH)+1 bits; word count needs $clog2(FRAME_WORDS)+1 bits; no wrap beyond the terminal values.

Test Plan:
All scenarios use the defaults except where noted. The bench encodes with a reference model: line = data XOR prev_line, starting at 0.

1. Decode only: line bits 0,1,1,0,0 with in_valid=1 -> dec_bit 0,1,0,1,0, each 1 cycle later; locked stays 0.
2. Sync + frame (FRAME_WORDS=2): data 0xA5, 0x3C, 0xF0 -> sync_found pulse after the 8th bit; word_valid with 0x3C then 0xF0; frame_done and word_valid coincide on 0xF0; locked 1 then 0.
3. Short-fill guard: reset, then data bits forming 0xA5 where only 7 bits follow a frame_done, e.g. frame end followed by 7 bits 0100101 -> no sync_found until a full 8-bit match.
4. Gaps: scenario 2 with in_valid=0 inserted for 3 cycles every other bit -> identical word_out values and pulse counts; outputs stable during gaps.
5. Reset mid-frame: assert rst after the 4th data bit of word 1 -> all outputs 0 immediately; a fresh encoder plus 0xA5, 0x11, 0x22 yields words 0x11, 0x22.
6. Payload containing SYNC: data 0xA5, 0xA5, 0x00 with FRAME_WORDS=2 -> exactly one sync_found; words 0xA5, 0x00.

Source files
------------

// File: rtl/diff_stream_decoder_if.sv
// Serial line in, decoded bit / sync / word stream out for diff_stream_decoder.
interface diff_stream_decoder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_bit;
  logic             dec_valid;
  logic             dec_bit;
  logic             sync_found;
  logic             locked;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             frame_done;

  modport master (
    output in_valid, in_bit,
    input  dec_valid, dec_bit, sync_found, locked, word_out, word_valid, frame_done
  );

  modport slave (
    input  in_valid, in_bit,
    output dec_valid, dec_bit, sync_found, locked, word_out, word_valid, frame_done
  );
endinterface

// File: rtl/diff_stream_decoder.sv
// Differential line decoder: recovers data = line ^ prev_line, hunts for a sync
// word, then deserializes FRAME_WORDS words MSB-first before hunting again.
//
// state | meaning
// HUNT  | comparing the last WIDTH decoded bits against SYNC
// DATA  | locked; collecting payload words, no sync comparison
module diff_stream_decoder #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  diff_stream_decoder_if.slave  bus
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int WW = $clog2(FRAME_WORDS) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] FILL_MAX  = BW'(WIDTH);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    fill_q, fill_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]    word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dec_valid_q, dec_valid_d;
  logic             dec_bit_q, dec_bit_d;
  logic             sync_q, sync_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_done_q, frame_done_d;

  logic             d;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_q       <= 1'b0;
      sh_q         <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      dec_valid_q  <= 1'b0;
      dec_bit_q    <= 1'b0;
      sync_q       <= 1'b0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      sh_q         <= sh_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      dec_valid_q  <= dec_valid_d;
      dec_bit_q    <= dec_bit_d;
      sync_q       <= sync_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    d            = bus.in_bit ^ prev_q;
    shifted      = {sh_q[WIDTH-2:0], d};
    state_d      = state_q;
    prev_d       = prev_q;
    sh_d         = sh_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    dec_bit_d    = dec_bit_q;
    dec_valid_d  = 1'b0;
    sync_d       = 1'b0;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;

    if (bus.in_valid) begin
      prev_d      = bus.in_bit;
      dec_bit_d   = d;
      dec_valid_d = 1'b1;
      sh_d        = shifted;
      case (state_q)
        HUNT: begin
          if (fill_q != FILL_MAX) fill_d = fill_q + BW'(1);
          // fill_q counts bits before this one, so WIDTH-1 means this is the WIDTH-th
          if (shifted == SYNC && fill_q >= BIT_LAST) begin
            sync_d     = 1'b1;
            state_d    = DATA;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            word_d       = shifted;
            word_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (word_cnt_q == WORD_LAST) begin
              frame_done_d = 1'b1;
              state_d      = HUNT;
              fill_d       = '0;
              word_cnt_d   = '0;
            end else begin
              word_cnt_d = word_cnt_q + WW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_bit    = dec_bit_q;
  assign bus.sync_found = sync_q;
  assign bus.locked     = (state_q == DATA);
  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_diff_stream_decoder.sv
// Directed bench for diff_stream_decoder (FRAME_WORDS=2) with a reference line encoder.
module tb_diff_stream_decoder;

  logic clk;
  logic rst;
  diff_stream_decoder_if #(.WIDTH(8)) bus ();

  diff_stream_decoder #(.WIDTH(8), .SYNC(8'hA5), .FRAME_WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic enc_prev;
  int bit_idx, sync_cnt, sync_at, wv_cnt, fd_cnt, fd_wv, gap_bad;
  logic [7:0] words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus.dec_valid, bus.dec_bit, bus.sync_found, bus.locked,
            bus.word_valid, bus.frame_done, bus.word_out};
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < words.size()) return {24'h0, words[i]};
    return 32'hDEAD;
  endfunction

  task automatic clear_track();
    bit_idx = 0; sync_cnt = 0; sync_at = 0; wv_cnt = 0; fd_cnt = 0; fd_wv = 0; gap_bad = 0;
    words.delete();
  endtask

  task automatic send_line(input logic l);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = l;
    @(posedge clk);
    #1;
    bit_idx++;
    if (bus.sync_found) begin sync_cnt++; sync_at = bit_idx; end
    if (bus.word_valid) begin wv_cnt++; words.push_back(bus.word_out); end
    if (bus.frame_done) fd_cnt++;
    if (bus.frame_done && bus.word_valid) fd_wv++;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    logic l;
    l = b ^ enc_prev;
    enc_prev = l;
    send_line(l);
  endtask

  task automatic idle(input int n);
    logic [7:0] pw;
    logic       pl;
    for (int k = 0; k < n; k++) begin
      pw = bus.word_out;
      pl = bus.locked;
      @(posedge clk);
      #1;
      if (bus.dec_valid || bus.sync_found || bus.word_valid || bus.frame_done ||
          bus.word_out !== pw || bus.locked !== pl) gap_bad++;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (gaps && (i % 2 == 0)) idle(3);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    enc_prev = 1'b0;
    clear_track();
  endtask

  initial begin
    logic [4:0] l1, e1;
    logic [6:0] short7;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    enc_prev = 1'b0;
    clear_track();
    #12;
    chk("reset_outputs", {18'h0, outs()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: raw line bits 0,1,1,0,0 decode to 0,1,0,1,0
    l1 = 5'b01100;
    e1 = 5'b01010;
    for (int i = 4; i >= 0; i--) begin
      send_line(l1[i]);
      chk("s1_dec_bit", {31'h0, bus.dec_bit}, {31'h0, e1[i]});
      chk("s1_dec_valid", {31'h0, bus.dec_valid}, 32'h1);
    end
    chk("s1_locked", {31'h0, bus.locked}, 32'h0);
    idle(1);
    chk("s1_dec_valid_drop", {31'h0, bus.dec_valid}, 32'h0);

    // Scenario 2: sync + two-word frame
    do_reset();
    send_byte(8'hA5, 0);
    chk("s2_sync_cnt", sync_cnt, 1);
    chk("s2_sync_at", sync_at, 8);
    chk("s2_locked_hi", {31'h0, bus.locked}, 32'h1);
    send_byte(8'h3C, 0);
    chk("s2_word0", wd(0), 32'h3C);
    chk("s2_locked_mid", {31'h0, bus.locked}, 32'h1);
    send_byte(8'hF0, 0);
    chk("s2_word1", wd(1), 32'hF0);
    chk("s2_wv_cnt", wv_cnt, 2);
    chk("s2_fd_cnt", fd_cnt, 1);
    chk("s2_fd_with_wv", fd_wv, 1);
    chk("s2_locked_lo", {31'h0, bus.locked}, 32'h0);

    // Scenario 3: last payload bit plus 7 fresh bits spell A5, must not sync
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h21, 0);
    chk("s3_fd_cnt", fd_cnt, 1);
    short7 = 7'b0100101;
    for (int i = 6; i >= 0; i--) send_bit(short7[i]);
    chk("s3_no_short_sync", sync_cnt, 1);
    chk("s3_unlocked", {31'h0, bus.locked}, 32'h0);
    send_byte(8'hA5, 0);
    chk("s3_resync_cnt", sync_cnt, 2);
    chk("s3_resync_at", sync_at, 39);
    send_byte(8'h5A, 0);
    send_byte(8'h0F, 0);
    chk("s3_word2", wd(2), 32'h5A);
    chk("s3_word3", wd(3), 32'h0F);
    chk("s3_fd_cnt2", fd_cnt, 2);

    // Scenario 4: scenario 2 with 3-cycle gaps every other bit
    do_reset();
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    send_byte(8'hF0, 1);
    chk("s4_sync_cnt", sync_cnt, 1);
    chk("s4_word0", wd(0), 32'h3C);
    chk("s4_word1", wd(1), 32'hF0);
    chk("s4_wv_cnt", wv_cnt, 2);
    chk("s4_fd_with_wv", fd_wv, 1);
    chk("s4_gap_stable", gap_bad, 0);

    // Scenario 5: asynchronous reset after 4 bits of the first word
    do_reset();
    send_byte(8'hA5, 0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    chk("s5_locked_before", {31'h0, bus.locked}, 32'h1);
    rst = 1'b1;
    #1;
    chk("s5_async_clear", {18'h0, outs()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    enc_prev = 1'b0;
    clear_track();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("s5_word0", wd(0), 32'h11);
    chk("s5_word1", wd(1), 32'h22);
    chk("s5_fd_cnt", fd_cnt, 1);

    // Scenario 6: SYNC inside payload is data
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    chk("s6_sync_cnt", sync_cnt, 1);
    chk("s6_word0", wd(0), 32'hA5);
    chk("s6_word1", wd(1), 32'h00);
    chk("s6_fd_cnt", fd_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
